multi_sum_uart_tx: RTL and testbench
====================================

# multi_sum_uart_tx

Parametrised operand-latch, adder and UART transmitter: the next generation of the SumLatchUART datapath. It captures N_OPS operands of DATA_W bits from a shared input bus, sums them at full precision, and on a start edge serialises the result over an 8N1 UART line. Output format is raw little-endian binary or uppercase ASCII hex with CR/LF. It sits behind the Tiny Tapeout wrapper and drives the board's UART TX pin and busy LED.

## Interface
Parameters:
- DATA_W, 4: operand width (≥1).
- N_OPS, 2: number of operand registers (≥2).
- CLKS_PER_BIT, 87: clk cycles per UART bit (≥2; 87 ≈ 115200 baud at 10 MHz).
- Derived localparams, not overridable:
  - RES_W = DATA_W + $clog2(N_OPS)
  - N_BYTES = ceil(RES_W/8)
  - N_HEX = ceil(RES_W/4)

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- data_input  in  DATA_W  shared operand bus.
- save_n  in  N_OPS  active-low per-operand load enables.
- fmt_ascii  in  1  0 = binary frame, 1 = ASCII hex frame; sampled at start.
- uart_tx_en  in  1  start request; rising edge triggers a frame.
- uart_txd  out  1  UART serial output, idle high.
- uart_tx_busy  out  1  high while a frame is in flight.
- result  out  RES_W  snapshot of the sum being or last transmitted.
- frame_done  out  1  one-cycle pulse on frame completion.

## Operation
- **Reset (reset_n=0 at a clock edge):**
  - Outputs: uart_txd=1, uart_tx_busy=0, result=0, frame_done=0.
  - Operands cleared to 0; FSM goes to IDLE.
  - The edge-detect register is set to 1, so a uart_tx_en held high through reset does not start a frame.
- **Operand load:** each cycle, op[i] <= data_input for every i with save_n[i]=0. Loads are allowed while busy and never affect a frame already in flight.
- **Sum:** unsigned, zero-extended to RES_W bits. It cannot overflow.
- **Start:** uart_tx_en=1 with the previous sample 0, and FSM in IDLE.
  - result <= sum, fmt latched, FSM moves to START.
  - An edge while busy is dropped, not queued.
- **Binary frame:** N_BYTES bytes, least-significant byte first; unused upper bits are 0.
- **ASCII frame:** N_HEX digits, most-significant digit first, followed by 0x0D then 0x0A.
  - Digits 0–9 encode as 0x30–0x39; 10–15 encode as 0x41–0x46.
- **UART:** 8N1, LSB first. Start bit 0, 8 data bits, stop bit 1, each held exactly CLKS_PER_BIT cycles.
- **FSM:** IDLE → START → DATA (8 bits) → STOP, then one of:
  - LOAD_NEXT → START when bytes remain;
  - IDLE when the last byte is done.
  - LOAD_NEXT takes zero line time: bytes are back-to-back and the next start bit immediately follows the stop bit.

## Timing
- Start edge sampled at edge k → uart_tx_busy=1 and uart_txd=0 from cycle k+1.
- Frame length: nbytes × 10 × CLKS_PER_BIT cycles.
  - nbytes = N_BYTES in binary mode, N_HEX+2 in ASCII mode.
- Completion: busy falls and frame_done pulses in the same cycle, the first cycle after the last stop bit; uart_txd stays 1.
- A new start edge is accepted the cycle after busy falls.
- Reset mid-frame: at the next edge uart_txd=1 and busy=0; no frame_done is generated.
- The baud counter and bit index restart from 0 at every START.

## Structure
- Package sum_uart_pkg holds:
  - state enum (IDLE, START, DATA, STOP, LOAD_NEXT);
  - constants ASCII_CR=0x0D, ASCII_LF=0x0A;
  - function hex_to_ascii(4-bit) → 8-bit.
- Sub-module uart_tx_byte: 8N1 serializer, parameter CLKS_PER_BIT.
  - Inputs: byte + valid. Outputs: ready, txd.
- The top level holds the operands, the adder tree, the byte sequencer and the edge detect.

## Test plan
Defaults (DATA_W=4, N_OPS=2, CLKS_PER_BIT=87) unless stated.
- Load op0=9, op1=7; fmt_ascii=0; pulse uart_tx_en → one byte 0x10 on the line, busy for 870 cycles, frame_done once, result=0x10.
- Same operands, fmt_ascii=1 → bytes 0x31 0x30 0x0D 0x0A, busy for 3480 cycles.
- op0=op1=15, fmt_ascii=1 → 0x31 0x45 0x0D 0x0A (sum 0x1E).
- During a frame, change operands and re-pulse uart_tx_en → transmitted bytes unchanged, no second frame; a pulse after busy falls sends the new sum.
- reset_n low during bit 3 of byte 0 → next cycle txd=1, busy=0, no frame_done, operands 0; a following start sends 0x00.
- DATA_W=8, N_OPS=4, all operands 255, binary → RES_W=10, bytes 0xFC 0x03 (sum 1020), busy for 1740 cycles.

Source files
------------

// File: rtl/sum_uart_pkg.sv
// Shared types, constants and helpers for the operand-sum UART transmitter.
package sum_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      LOAD_NEXT
   } state_e;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   // Uppercase hex digit: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'.
   function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A new byte may be accepted in the final cycle of the
// stop bit, so consecutive bytes go out with no idle gap between them.
//
// state | meaning
// IDLE  | line idle high, ready for a byte
// START | driving the start bit (0)
// DATA  | shifting out 8 data bits, LSB first
// STOP  | driving the stop bit (1); last cycle hands over to the next byte
module uart_tx_byte
   import sum_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] byte_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic       txd_o
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             baud_tc;

   assign baud_tc = (cnt_q == '0);

   // Serializer state registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   // Bit timing, next state and line level.
   always_comb begin
      state_d = state_q;
      cnt_d   = baud_tc ? cnt_q : cnt_q - CNT_W'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      ready_o = 1'b0;
      txd_o   = 1'b1;
      case (state_q)
         IDLE: begin
            ready_o = 1'b1;
            cnt_d   = cnt_q;
         end
         START: begin
            txd_o = 1'b0;
            if (baud_tc) begin
               state_d = DATA;
               cnt_d   = CNT_RELOAD;
               bit_d   = '0;
            end
         end
         DATA: begin
            txd_o = shift_q[0];
            if (baud_tc) begin
               cnt_d   = CNT_RELOAD;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (baud_tc) begin
               ready_o = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (ready_o && valid_i) begin
         state_d = START;
         cnt_d   = CNT_RELOAD;
         bit_d   = '0;
         shift_d = byte_i;
      end
   end

endmodule

// File: rtl/multi_sum_uart_tx.sv
// Operand latches, full-precision adder and frame sequencer feeding an 8N1
// serializer. Frames are raw little-endian binary or uppercase hex + CR/LF.
//
// state | meaning
// IDLE  | no frame in flight, waiting for a rising edge on uart_tx_en
// DATA  | frame in flight; serializer owns the current byte
// (the hand-over to the next byte happens in the serializer's last stop-bit
//  cycle, so loading the next byte costs no line time)
module multi_sum_uart_tx
   import sum_uart_pkg::*;
#(
   parameter  int DATA_W       = 4,
   parameter  int N_OPS        = 2,
   parameter  int CLKS_PER_BIT = 87,
   localparam int RES_W        = DATA_W + $clog2(N_OPS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] data_input,
   input  logic [N_OPS-1:0]  save_n,
   input  logic              fmt_ascii,
   input  logic              uart_tx_en,
   output logic              uart_txd,
   output logic              uart_tx_busy,
   output logic [RES_W-1:0]  result,
   output logic              frame_done
);

   localparam int N_BYTES = (RES_W + 7) / 8;
   localparam int N_HEX   = (RES_W + 3) / 4;
   localparam int BIN_W   = N_BYTES * 8;
   localparam int HEX_W   = N_HEX * 4;
   localparam int IDX_W   = $clog2(N_HEX + 2);

   logic [DATA_W-1:0] op_q [N_OPS];
   logic [RES_W-1:0]  sum_w;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [RES_W-1:0]  result_q, result_d;
   logic              fmt_q, fmt_d;
   logic              en_q;
   logic              done_q, done_d;

   logic              start_edge, last_byte;
   logic              ser_valid, ser_ready;
   logic [RES_W-1:0]  src_val;
   logic              src_fmt;
   logic [IDX_W-1:0]  src_idx, rev_idx;
   logic [BIN_W-1:0]  bin_sh;
   logic [HEX_W-1:0]  hex_sh;
   logic [7:0]        tx_byte;

   // Operand registers; loads are independent of any frame in flight.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < N_OPS; i++) op_q[i] <= '0;
      end else begin
         for (int i = 0; i < N_OPS; i++) begin
            if (!save_n[i]) op_q[i] <= data_input;
         end
      end
   end

   // Zero-extended sum of all operands; RES_W is wide enough to never wrap.
   always_comb begin
      sum_w = '0;
      for (int i = 0; i < N_OPS; i++) sum_w = sum_w + RES_W'(op_q[i]);
   end

   // Sequencer registers; edge detect resets high so a held enable is ignored.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         result_q <= '0;
         fmt_q    <= 1'b0;
         en_q     <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         fmt_q    <= fmt_d;
         en_q     <= uart_tx_en;
         done_q   <= done_d;
      end
   end

   assign start_edge = uart_tx_en & ~en_q;
   assign last_byte  = fmt_q ? (idx_q == IDX_W'(N_HEX + 1))
                             : (idx_q == IDX_W'(N_BYTES - 1));

   // Frame sequencing: start on an edge in IDLE, feed bytes until the last.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      result_d  = result_q;
      fmt_d     = fmt_q;
      done_d    = 1'b0;
      ser_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_edge) begin
               ser_valid = 1'b1;
               state_d   = DATA;
               idx_d     = '0;
               result_d  = sum_w;
               fmt_d     = fmt_ascii;
            end
         end
         DATA: begin
            if (ser_ready) begin
               if (last_byte) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  ser_valid = 1'b1;
                  idx_d     = idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Byte to hand over: the first byte comes straight from the live sum so
   // its start bit can begin the cycle after the start edge.
   always_comb begin
      if (state_q == IDLE) begin
         src_val = sum_w;
         src_fmt = fmt_ascii;
         src_idx = '0;
      end else begin
         src_val = result_q;
         src_fmt = fmt_q;
         src_idx = idx_q + IDX_W'(1);
      end
      rev_idx = IDX_W'(N_HEX - 1) - src_idx;
      bin_sh  = BIN_W'(src_val) >> {src_idx, 3'b000};
      hex_sh  = HEX_W'(src_val) >> {rev_idx, 2'b00};
      if (!src_fmt) begin
         tx_byte = bin_sh[7:0];
      end else if (src_idx < IDX_W'(N_HEX)) begin
         tx_byte = hex_to_ascii(hex_sh[3:0]);
      end else if (src_idx == IDX_W'(N_HEX)) begin
         tx_byte = ASCII_CR;
      end else begin
         tx_byte = ASCII_LF;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_ser (
      .clk     (clk),
      .reset_n (reset_n),
      .byte_i  (tx_byte),
      .valid_i (ser_valid),
      .ready_o (ser_ready),
      .txd_o   (uart_txd)
   );

   assign uart_tx_busy = (state_q != IDLE);
   assign result       = result_q;
   assign frame_done   = done_q;

endmodule

// File: tb/tb_multi_sum_uart_tx.sv
// Scoreboard bench: stimulus pushes expected bytes computed from an
// arithmetic model; UART receiver processes decode the line and compare.
module tb_multi_sum_uart_tx;

   localparam int CPB  = 87;
   localparam int DW_A = 4;
   localparam int NO_A = 2;
   localparam int DW_B = 8;
   localparam int NO_B = 4;
   localparam int RW_A = DW_A + $clog2(NO_A);
   localparam int RW_B = DW_B + $clog2(NO_B);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic [DW_A-1:0] din_a;
   logic [NO_A-1:0] save_a;
   logic            fmt_a, en_a, txd_a, busy_a, done_a;
   logic [RW_A-1:0] res_a;
   logic [DW_B-1:0] din_b;
   logic [NO_B-1:0] save_b;
   logic            fmt_b, en_b, txd_b, busy_b, done_b;
   logic [RW_B-1:0] res_b;

   multi_sum_uart_tx #(.DATA_W(DW_A), .N_OPS(NO_A), .CLKS_PER_BIT(CPB)) dut_a (
      .clk(clk), .reset_n(rst_n), .data_input(din_a), .save_n(save_a),
      .fmt_ascii(fmt_a), .uart_tx_en(en_a), .uart_txd(txd_a),
      .uart_tx_busy(busy_a), .result(res_a), .frame_done(done_a));

   multi_sum_uart_tx #(.DATA_W(DW_B), .N_OPS(NO_B), .CLKS_PER_BIT(CPB)) dut_b (
      .clk(clk), .reset_n(rst_n), .data_input(din_b), .save_n(save_b),
      .fmt_ascii(fmt_b), .uart_tx_en(en_b), .uart_txd(txd_b),
      .uart_tx_busy(busy_b), .result(res_b), .frame_done(done_b));

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;
   int rst_epoch  = 0;
   int done_cnt [2];
   int done_base[2];
   int t_rise   [2];
   int exp_res  [2];
   int mops     [2][4];
   int qa[$];
   int qb[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (done_a === 1'b1) done_cnt[0]++;
      if (done_b === 1'b1) done_cnt[1]++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int dw(input int w);   return w ? DW_B : DW_A; endfunction
   function automatic int nops(input int w); return w ? NO_B : NO_A; endfunction
   function automatic int resw(input int w); return w ? RW_B : RW_A; endfunction
   function automatic logic get_txd(input int w);  return w ? txd_b  : txd_a;  endfunction
   function automatic logic get_busy(input int w); return w ? busy_b : busy_a; endfunction
   function automatic logic get_done(input int w); return w ? done_b : done_a; endfunction
   function automatic int get_res(input int w);    return w ? int'(res_b) : int'(res_a); endfunction

   function automatic int model_sum(input int w);
      int s = 0;
      for (int i = 0; i < nops(w); i++) s += mops[w][i];
      return s;
   endfunction

   function automatic int frame_len(input int w, input bit fmt);
      int nb = fmt ? ((resw(w) + 3) / 4 + 2) : ((resw(w) + 7) / 8);
      return nb * 10 * CPB;
   endfunction

   task automatic push_byte(input int w, input int v);
      if (w == 0) qa.push_back(v); else qb.push_back(v);
   endtask

   task automatic push_expected(input int w, input bit fmt);
      int s = model_sum(w);
      if (!fmt) begin
         for (int b = 0; b < (resw(w) + 7) / 8; b++) push_byte(w, (s >> (8 * b)) & 255);
      end else begin
         for (int d = (resw(w) + 3) / 4 - 1; d >= 0; d--) begin
            int n = (s >> (4 * d)) & 15;
            push_byte(w, (n < 10) ? (48 + n) : (65 + n - 10));
         end
         push_byte(w, 13);
         push_byte(w, 10);
      end
   endtask

   // Line receiver: start bit detected at a falling clock edge, then each
   // bit is sampled near its middle.
   task automatic rx_loop(input int w);
      logic [7:0] d;
      logic       st, sb;
      int         ep, e;
      forever begin
         @(negedge clk);
         if (get_txd(w) !== 1'b0) continue;
         ep = rst_epoch;
         repeat (CPB / 2 - 1) @(negedge clk);
         st = get_txd(w);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            d[i] = get_txd(w);
         end
         repeat (CPB) @(negedge clk);
         sb = get_txd(w);
         if (ep != rst_epoch) continue;
         check($sformatf("rx%0d_start_bit", w), {31'b0, st}, 32'd0);
         check($sformatf("rx%0d_stop_bit", w), {31'b0, sb}, 32'd1);
         if (w == 0) begin
            check("rx0_byte_expected", (qa.size() > 0), 32'd1);
            if (qa.size() > 0) begin e = qa.pop_front(); check("rx0_byte", {24'b0, d}, e); end
         end else begin
            check("rx1_byte_expected", (qb.size() > 0), 32'd1);
            if (qb.size() > 0) begin e = qb.pop_front(); check("rx1_byte", {24'b0, d}, e); end
         end
      end
   endtask

   initial rx_loop(0);
   initial rx_loop(1);

   task automatic load_op(input int w, input int mask, input int val);
      @(negedge clk);
      if (w == 0) begin din_a = DW_A'(val); save_a = NO_A'(~mask); end
      else        begin din_b = DW_B'(val); save_b = NO_B'(~mask); end
      @(negedge clk);
      save_a = '1;
      save_b = '1;
      for (int i = 0; i < nops(w); i++)
         if ((mask >> i) & 1) mops[w][i] = val & ((1 << dw(w)) - 1);
   endtask

   task automatic do_start(input int w, input bit fmt, input bit expect_frame);
      @(negedge clk);
      if (w == 0) begin fmt_a = fmt; en_a = 1'b1; end
      else        begin fmt_b = fmt; en_b = 1'b1; end
      if (expect_frame) begin
         push_expected(w, fmt);
         exp_res[w]   = model_sum(w);
         done_base[w] = done_cnt[w];
      end
      @(negedge clk);
      if (expect_frame) begin
         check($sformatf("start%0d_busy", w), {31'b0, get_busy(w)}, 32'd1);
         check($sformatf("start%0d_txd_low", w), {31'b0, get_txd(w)}, 32'd0);
         t_rise[w] = cyc;
      end
      en_a = 1'b0;
      en_b = 1'b0;
   endtask

   task automatic wait_done(input int w, input int exp_len, input string tag);
      int n = 0;
      while (get_busy(w) === 1'b1 && n < exp_len + 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_busy_fell"}, {31'b0, get_busy(w)}, 32'd0);
      check({tag, "_busy_len"}, cyc - t_rise[w], exp_len);
      check({tag, "_done_with_fall"}, {31'b0, get_done(w)}, 32'd1);
      check({tag, "_result"}, get_res(w), exp_res[w]);
      @(negedge clk);
      #1;
      check({tag, "_done_once"}, done_cnt[w] - done_base[w], 32'd1);
      check({tag, "_done_low"}, {31'b0, get_done(w)}, 32'd0);
      check({tag, "_txd_idle"}, {31'b0, get_txd(w)}, 32'd1);
      check({tag, "_all_bytes_seen"}, (w == 0) ? qa.size() : qb.size(), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bit f;
      rst_n  = 1'b0;
      din_a  = '0; save_a = '1; fmt_a = 1'b0; en_a = 1'b1;
      din_b  = '0; save_b = '1; fmt_b = 1'b0; en_b = 1'b0;
      for (int w = 0; w < 2; w++) for (int i = 0; i < 4; i++) mops[w][i] = 0;
      repeat (4) @(negedge clk);
      check("reset_txd", {31'b0, txd_a}, 32'd1);
      check("reset_busy", {31'b0, busy_a}, 32'd0);
      check("reset_result", {27'b0, res_a}, 32'd0);
      check("reset_done", {31'b0, done_a}, 32'd0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("held_en_no_start", {31'b0, busy_a}, 32'd0);
      en_a = 1'b0;
      repeat (3) @(negedge clk);

      // 9 + 7 in binary and ASCII
      load_op(0, 1, 9);
      load_op(0, 2, 7);
      do_start(0, 1'b0, 1'b1);
      wait_done(0, 870, "bin_9_7");
      do_start(0, 1'b1, 1'b1);
      wait_done(0, 3480, "asc_9_7");

      // 15 + 15 -> "1E"
      load_op(0, 3, 15);
      do_start(0, 1'b1, 1'b1);
      wait_done(0, 3480, "asc_15_15");

      // operand change and re-pulse while busy are ignored by the frame
      load_op(0, 1, 9);
      load_op(0, 2, 7);
      do_start(0, 1'b0, 1'b1);
      repeat (200) @(negedge clk);
      load_op(0, 1, 3);
      load_op(0, 2, 4);
      do_start(0, 1'b0, 1'b0);
      exp_res[0] = 16;
      wait_done(0, 870, "busy_repulse");
      base = done_cnt[0];
      repeat (50) @(negedge clk);
      check("no_queued_frame_busy", {31'b0, busy_a}, 32'd0);
      check("no_queued_frame_done", done_cnt[0] - base, 32'd0);
      do_start(0, 1'b0, 1'b1);
      wait_done(0, 870, "new_sum_after");

      // reset in bit 3 of byte 0
      load_op(0, 3, 5);
      do_start(0, 1'b0, 1'b1);
      repeat (4 * CPB + 10) @(negedge clk);
      rst_n = 1'b0;
      qa.delete();
      qb.delete();
      for (int w = 0; w < 2; w++) for (int i = 0; i < 4; i++) mops[w][i] = 0;
      rst_epoch++;
      base = done_cnt[0];
      @(negedge clk);
      check("midreset_txd", {31'b0, txd_a}, 32'd1);
      check("midreset_busy", {31'b0, busy_a}, 32'd0);
      check("midreset_result", {27'b0, res_a}, 32'd0);
      rst_n = 1'b1;
      repeat (1000) @(negedge clk);
      check("midreset_no_done", done_cnt[0] - base, 32'd0);
      do_start(0, 1'b0, 1'b1);
      wait_done(0, 870, "after_reset_zero");

      // randomized frames on the default instance
      repeat (3) begin
         load_op(0, $urandom_range(1, 3), $urandom_range(0, 15));
         load_op(0, $urandom_range(1, 3), $urandom_range(0, 15));
         f = 1'($urandom_range(0, 1));
         do_start(0, f, 1'b1);
         wait_done(0, frame_len(0, f), "rand_a");
      end

      // wide instance: 4 x 255 = 1020 -> FC 03
      load_op(1, 15, 255);
      do_start(1, 1'b0, 1'b1);
      wait_done(1, 1740, "b_bin_1020");
      load_op(1, $urandom_range(1, 15), $urandom_range(0, 255));
      load_op(1, $urandom_range(1, 15), $urandom_range(0, 255));
      do_start(1, 1'b1, 1'b1);
      wait_done(1, 4350, "b_rand_asc");
      load_op(1, $urandom_range(1, 15), $urandom_range(0, 255));
      do_start(1, 1'b0, 1'b1);
      wait_done(1, 1740, "b_rand_bin");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
